alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Upstream control/operand stage for the 8-bit signed ALU. Accepts one command at a time over
//  a valid/ready handshake and registers the operands and opcode that drive the ALU. Captures the
//  ALU result and flags one cycle later into an accumulator and a result register. Returns the
//  result over a second valid/ready handshake. Commands can chain through the accumulator.
// PARAMETERS
//  WIDTH          8   data width; must equal the ALU WIDTH
//  ALU_SEL_WIDTH  3   opcode width; must equal the ALU select width
//  CNT_WIDTH      16  width of the completed-operation counter
// PORTS
//  clk           in   1              single clock, rising edge
//  rst           in   1              asynchronous, active-high reset
//  cmd_valid     in   1              command present
//  cmd_ready     out  1              sequencer can accept a command
//  cmd_op        in   ALU_SEL_WIDTH  opcode: 001 add, 010 sub, 011 mul, 100 a/2, other pass b
//  cmd_a         in   WIDTH          signed operand A
//  cmd_b         in   WIDTH          signed operand B
//  cmd_use_acc   in   1              1: operand A is taken from the accumulator, cmd_a is ignored
//  acc_clr       in   1              synchronous clear of the accumulator; honoured only in IDLE
//  alu_bus_a     out  WIDTH          registered operand A to the ALU
//  alu_bus_b     out  WIDTH          registered operand B to the ALU
//  alu_sel       out  ALU_SEL_WIDTH  registered opcode to the ALU
//  alu_out       in   WIDTH          ALU result (combinational from the ALU)
//  alu_zero      in   1              ALU zero flag
//  alu_negative  in   1              ALU negative flag
//  res_valid     out  1              result available
//  res_ready     in   1              consumer takes the result
//  res_data      out  WIDTH          captured signed result
//  res_zero      out  1              captured zero flag
//  res_negative  out  1              captured negative flag
//  acc           out  WIDTH          accumulator value
//  op_count      out  CNT_WIDTH      number of results delivered
// BEHAVIOUR
//  Reset: state=IDLE. Every register (alu_bus_a/b, alu_sel, acc, res_*, op_count) goes to 0.
//   With alu_sel=000 the ALU passes bus_b.
//  FSM states IDLE -> EXEC -> RESP -> IDLE. cmd_ready = (state==IDLE), combinational from state.
//  IDLE: on cmd_valid && cmd_ready:
//   - alu_bus_a <= cmd_use_acc ? acc : cmd_a
//   - alu_bus_b <= cmd_b; alu_sel <= cmd_op
//   - go to EXEC
//  IDLE acc_clr:
//   - sets acc <= 0.
//   - If acc_clr arrives together with an accepted cmd_use_acc command, operand A is 0.
//  EXEC (exactly 1 cycle):
//   - acc <= alu_out; res_data <= alu_out
//   - res_zero <= alu_zero; res_negative <= alu_negative
//   - res_valid <= 1; go to RESP.
//  RESP: hold res_valid and every res_* / alu_* output stable until res_ready.
//   - On res_valid && res_ready: res_valid <= 0, op_count <= op_count+1, state <= IDLE.
//  Latency:
//   - Command accepted at edge k; res_valid is high after edge k+1.
//   - With res_ready held high, the result transfers at edge k+2 and cmd_ready is high again
//     after edge k+2. Maximum throughput is 1 operation per 3 cycles.
//  res_ready while not in RESP is ignored. acc_clr outside IDLE is ignored (it is not queued).
//  Arithmetic is performed by the ALU, truncated to WIDTH; this block adds no saturation.
//   a/2 is signed division, truncating toward zero.
//  op_count wraps from 2^CNT_WIDTH-1 to 0.
//  rst asserted in any state aborts the in-flight operation with no result delivered.
//   All outputs return to their reset values immediately.
// TESTING  (WIDTH=8)
//  add, a=5 b=3, res_ready=1 -> res_valid 1 cycle after accept; res_data=8, zero=0, neg=0, acc=8
//  sub, a=3 b=5 -> res_data=0xFE (-2), neg=1; then mul, use_acc=1 b=-2 -> alu_bus_a=0xFE,
//   res_data=0x04
//  op=100, a=-7 -> res_data=-3 (0xFD). op=000, a=9 b=-1 -> pass b: res_data=0xFF, neg=1.
//   sub, a=4 b=4 -> zero=1
//  Backpressure: res_ready=0 for 4 cycles -> res_valid and res_data held stable, cmd_ready=0,
//   a second cmd_valid is not accepted, op_count unchanged until the transfer
//  acc_clr=1 with an accepted add, use_acc=1 b=6 and acc=8 -> res_data=6
//  rst pulsed in EXEC -> res_valid=0, acc=0, op_count=0, cmd_ready=1 after release; the next
//   command completes normally

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Command/operand sequencer for the 8-bit signed ALU: accepts a command,
// drives registered operands to the ALU, captures the result one cycle
// later and returns it over a valid/ready handshake.
module alu_op_sequencer #(
  parameter int WIDTH         = 8,
  parameter int ALU_SEL_WIDTH = 3,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ALU_SEL_WIDTH-1:0] cmd_op,
  input  logic [WIDTH-1:0]         cmd_a,
  input  logic [WIDTH-1:0]         cmd_b,
  input  logic                     cmd_use_acc,
  input  logic                     acc_clr,
  output logic [WIDTH-1:0]         alu_bus_a,
  output logic [WIDTH-1:0]         alu_bus_b,
  output logic [ALU_SEL_WIDTH-1:0] alu_sel,
  input  logic [WIDTH-1:0]         alu_out,
  input  logic                     alu_zero,
  input  logic                     alu_negative,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic                     res_zero,
  output logic                     res_negative,
  output logic [WIDTH-1:0]         acc,
  output logic [CNT_WIDTH-1:0]     op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   res_fire;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and handshake strobes
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    accept    = 1'b0;
    res_fire  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        accept    = cmd_valid;
        if (cmd_valid) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        res_fire = res_valid && res_ready;
        if (res_fire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/opcode registers toward the ALU; a same-cycle acc_clr forces operand A to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_bus_a <= '0;
      alu_bus_b <= '0;
      alu_sel   <= '0;
    end else if (accept) begin
      if (cmd_use_acc) alu_bus_a <= acc_clr ? '0 : acc;
      else             alu_bus_a <= cmd_a;
      alu_bus_b <= cmd_b;
      alu_sel   <= cmd_op;
    end
  end

  // Accumulator: cleared on request in IDLE, loaded with the ALU result in EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (state == IDLE && acc_clr) begin
      acc <= '0;
    end else if (state == EXEC) begin
      acc <= alu_out;
    end
  end

  // Result capture and response handshake, delivered-result counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_zero     <= 1'b0;
      res_negative <= 1'b0;
      op_count     <= '0;
    end else if (state == EXEC) begin
      res_valid    <= 1'b1;
      res_data     <= alu_out;
      res_zero     <= alu_zero;
      res_negative <= alu_negative;
    end else if (res_fire) begin
      res_valid <= 1'b0;
      op_count  <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer with a behavioural 8-bit ALU.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_a, cmd_b;
  logic        cmd_use_acc, acc_clr;
  logic [7:0]  alu_bus_a, alu_bus_b;
  logic [2:0]  alu_sel;
  logic [7:0]  alu_out;
  logic        alu_zero, alu_negative;
  logic        res_valid, res_ready;
  logic [7:0]  res_data;
  logic        res_zero, res_negative;
  logic [7:0]  acc;
  logic [15:0] op_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(8), .ALU_SEL_WIDTH(3), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .acc_clr(acc_clr),
    .alu_bus_a(alu_bus_a), .alu_bus_b(alu_bus_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_negative(alu_negative),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_zero(res_zero), .res_negative(res_negative),
    .acc(acc), .op_count(op_count)
  );

  // Behavioural signed ALU
  logic signed [7:0] sa, sb;
  always_comb begin
    sa = alu_bus_a;
    sb = alu_bus_b;
    case (alu_sel)
      3'b001:  alu_out = sa + sb;
      3'b010:  alu_out = sa - sb;
      3'b011:  alu_out = sa * sb;
      3'b100:  alu_out = sa / 8'sd2;
      default: alu_out = sb;
    endcase
    alu_zero     = (alu_out == 8'h00);
    alu_negative = alu_out[7];
  end

  // Present one command for a single cycle; returns #1 after the accepting edge
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic use_acc, input logic clr);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    cmd_use_acc = use_acc; acc_clr = clr;
    @(posedge clk); #1;
    cmd_valid = 1'b0; acc_clr = 1'b0; cmd_use_acc = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_use_acc = 1'b0; acc_clr = 1'b0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    checks++; if ({alu_bus_a, alu_bus_b, alu_sel} !== 19'h0) begin errors++; $display("FAIL reset_alu_regs got=%h exp=0", {alu_bus_a, alu_bus_b, alu_sel}); end
    checks++; if ({acc, res_data, res_zero, res_negative} !== 18'h0) begin errors++; $display("FAIL reset_res_regs got=%h exp=0", {acc, res_data, res_zero, res_negative}); end
    checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL reset_op_count got=%0d exp=0", op_count); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_add_latency();
    res_ready = 1'b1;
    send(3'b001, 8'd5, 8'd3, 1'b0, 1'b0);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL add_valid_early got=%b exp=0", res_valid); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL add_ready_exec got=%b exp=0", cmd_ready); end
    checks++; if ({alu_bus_a, alu_bus_b, alu_sel} !== {8'd5, 8'd3, 3'b001}) begin errors++; $display("FAIL add_alu_bus got=%h exp=%h", {alu_bus_a, alu_bus_b, alu_sel}, {8'd5, 8'd3, 3'b001}); end
    step();
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", res_valid); end
    checks++; if ({res_data, res_zero, res_negative} !== {8'd8, 2'b00}) begin errors++; $display("FAIL add_result got=%h exp=%h", {res_data, res_zero, res_negative}, {8'd8, 2'b00}); end
    checks++; if (acc !== 8'd8) begin errors++; $display("FAIL add_acc got=%h exp=08", acc); end
    step();
    checks++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL add_transfer got valid=%b ready=%b exp valid=0 ready=1", res_valid, cmd_ready); end
    checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL add_op_count got=%0d exp=1", op_count); end
  endtask

  task automatic test_chain();
    res_ready = 1'b1;
    send(3'b010, 8'd3, 8'd5, 1'b0, 1'b0);
    step();
    checks++; if ({res_data, res_zero, res_negative} !== {8'hFE, 2'b01}) begin errors++; $display("FAIL sub_neg_result got=%h exp=%h", {res_data, res_zero, res_negative}, {8'hFE, 2'b01}); end
    step();
    send(3'b011, 8'd77, 8'hFE, 1'b1, 1'b0);
    checks++; if (alu_bus_a !== 8'hFE) begin errors++; $display("FAIL chain_bus_a got=%h exp=FE", alu_bus_a); end
    step();
    checks++; if ({res_data, res_zero, res_negative} !== {8'h04, 2'b00}) begin errors++; $display("FAIL chain_mul_result got=%h exp=%h", {res_data, res_zero, res_negative}, {8'h04, 2'b00}); end
    checks++; if (acc !== 8'h04) begin errors++; $display("FAIL chain_acc got=%h exp=04", acc); end
    step();
    checks++; if (op_count !== 16'd3) begin errors++; $display("FAIL chain_op_count got=%0d exp=3", op_count); end
  endtask

  task automatic test_ops();
    res_ready = 1'b1;
    send(3'b100, 8'hF9, 8'd0, 1'b0, 1'b0);
    step();
    checks++; if ({res_data, res_negative} !== {8'hFD, 1'b1}) begin errors++; $display("FAIL half_neg got=%h exp=%h", {res_data, res_negative}, {8'hFD, 1'b1}); end
    step();
    send(3'b000, 8'd9, 8'hFF, 1'b0, 1'b0);
    step();
    checks++; if ({res_data, res_zero, res_negative} !== {8'hFF, 2'b01}) begin errors++; $display("FAIL pass_b got=%h exp=%h", {res_data, res_zero, res_negative}, {8'hFF, 2'b01}); end
    step();
    send(3'b010, 8'd4, 8'd4, 1'b0, 1'b0);
    step();
    checks++; if ({res_data, res_zero, res_negative} !== {8'h00, 2'b10}) begin errors++; $display("FAIL sub_zero got=%h exp=%h", {res_data, res_zero, res_negative}, {8'h00, 2'b10}); end
    step();
    checks++; if (op_count !== 16'd6) begin errors++; $display("FAIL ops_op_count got=%0d exp=6", op_count); end
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    send(3'b001, 8'd1, 8'd2, 1'b0, 1'b0);
    step();
    // Offer a competing command and a clear while the result is stalled
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'b010; cmd_a = 8'd50; cmd_b = 8'd7; acc_clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if ({res_valid, res_data, cmd_ready} !== {1'b1, 8'd3, 1'b0}) begin errors++; $display("FAIL bp_hold[%0d] got valid=%b data=%h ready=%b exp valid=1 data=03 ready=0", i, res_valid, res_data, cmd_ready); end
      checks++; if ({alu_bus_a, alu_bus_b, alu_sel, acc} !== {8'd1, 8'd2, 3'b001, 8'd3}) begin errors++; $display("FAIL bp_regs[%0d] got=%h exp=%h", i, {alu_bus_a, alu_bus_b, alu_sel, acc}, {8'd1, 8'd2, 3'b001, 8'd3}); end
      checks++; if (op_count !== 16'd6) begin errors++; $display("FAIL bp_op_count[%0d] got=%0d exp=6", i, op_count); end
    end
    @(negedge clk);
    cmd_valid = 1'b0; acc_clr = 1'b0; res_ready = 1'b1;
    step();
    checks++; if ({res_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1", res_valid, cmd_ready); end
    checks++; if (op_count !== 16'd7) begin errors++; $display("FAIL bp_op_count_after got=%0d exp=7", op_count); end
    checks++; if (acc !== 8'd3) begin errors++; $display("FAIL bp_acc_not_cleared got=%h exp=03", acc); end
  endtask

  task automatic test_acc_clr();
    res_ready = 1'b1;
    send(3'b001, 8'd5, 8'd3, 1'b0, 1'b0);
    step(); step();
    checks++; if (acc !== 8'd8) begin errors++; $display("FAIL clr_pre_acc got=%h exp=08", acc); end
    send(3'b001, 8'd99, 8'd6, 1'b1, 1'b1);
    checks++; if (alu_bus_a !== 8'd0) begin errors++; $display("FAIL clr_bus_a got=%h exp=00", alu_bus_a); end
    step();
    checks++; if (res_data !== 8'd6) begin errors++; $display("FAIL clr_result got=%h exp=06", res_data); end
    step();
    checks++; if (op_count !== 16'd9) begin errors++; $display("FAIL clr_op_count got=%0d exp=9", op_count); end
  endtask

  task automatic test_reset_in_exec();
    res_ready = 1'b1;
    send(3'b001, 8'd10, 8'd20, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    checks++; if ({res_valid, acc, op_count, cmd_ready} !== {1'b0, 8'd0, 16'd0, 1'b1}) begin errors++; $display("FAIL rst_exec got valid=%b acc=%h cnt=%0d ready=%b exp 0/00/0/1", res_valid, acc, op_count, cmd_ready); end
    checks++; if ({alu_bus_a, alu_bus_b, alu_sel} !== 19'h0) begin errors++; $display("FAIL rst_exec_alu got=%h exp=0", {alu_bus_a, alu_bus_b, alu_sel}); end
    @(negedge clk); rst = 1'b0;
    step();
    checks++; if ({res_valid, cmd_ready} !== 2'b01) begin errors++; $display("FAIL rst_idle got valid=%b ready=%b exp valid=0 ready=1", res_valid, cmd_ready); end
    send(3'b001, 8'd2, 8'd2, 1'b0, 1'b0);
    step();
    checks++; if ({res_valid, res_data} !== {1'b1, 8'd4}) begin errors++; $display("FAIL rst_next_result got valid=%b data=%h exp valid=1 data=04", res_valid, res_data); end
    step();
    checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL rst_next_op_count got=%0d exp=1", op_count); end
  endtask

  initial begin
    test_reset();
    test_add_latency();
    test_chain();
    test_ops();
    test_backpressure();
    test_acc_clr();
    test_reset_in_exec();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
